// File: rtl/lalu_top.sv
// lalu_top: 640x480@60 VGA timing filled with a register-held colour that PS/2 scancodes edit.
// Define LALU_TEST_PATTERN_EN to replace the fill with eight 80-pixel-wide colour bars.
module lalu_top (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_SYNC_N,
    output logic       VGA_BLANK_N,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       suspended
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_VIS    = 640;
    localparam int unsigned H_SYNC_S = 656;
    localparam int unsigned H_SYNC_E = 751;
    localparam int unsigned H_LAST   = 799;
    localparam int unsigned V_VIS    = 480;
    localparam int unsigned V_SYNC_S = 490;
    localparam int unsigned V_SYNC_E = 491;
    localparam int unsigned V_LAST   = 524;
    localparam int unsigned WDW      = 16;
    localparam int unsigned BCW      = 4;

    localparam logic [23:0] COLOUR_RST = 24'h000080;
    localparam logic [7:0]  KEY_BRK    = 8'hF0;
    localparam logic [7:0]  KEY_EXT    = 8'hE0;
    localparam logic [7:0]  KEY_R      = 8'h2D;
    localparam logic [7:0]  KEY_G      = 8'h34;
    localparam logic [7:0]  KEY_B      = 8'h32;
    localparam logic [7:0]  KEY_SPACE  = 8'h29;
    localparam logic [7:0]  KEY_ESC    = 8'h76;

    logic            pe_q, pe_d;
    logic            vga_clk_q, vga_clk_d;
    logic [CW-1:0]   h_q, h_d, v_q, v_d;
    logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]      ps2c_sync_q, ps2c_sync_d, ps2d_sync_q, ps2d_sync_d;
    logic            ps2c_prev_q, ps2c_prev_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [23:0]     colour_q, colour_d;
    logic            brk_q, brk_d;
    logic            suspended_q, suspended_d;

    logic            visible_c;
    logic [23:0]     pixel_c;
    logic            fall_c;
    logic [10:0]     frame_c;
    logic            byte_ok_c;
`ifdef LALU_TEST_PATTERN_EN
    logic [2:0]      bar_c;
`endif

    // VGA timing: counters and registered outputs advance on the pixel-enable cycle
    always_comb begin
        pe_d      = ~pe_q;
        vga_clk_d = pe_q;
        h_d       = h_q;
        v_d       = v_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        visible_c = (h_q < CW'(H_VIS)) && (v_q < CW'(V_VIS));
`ifdef LALU_TEST_PATTERN_EN
        bar_c     = 3'(h_q / CW'(80));
        pixel_c   = {{8{bar_c[2]}}, {8{bar_c[1]}}, {8{bar_c[0]}}};
`else
        pixel_c   = colour_q;
`endif
        if (pe_q) begin
            hs_d      = !((h_q >= CW'(H_SYNC_S)) && (h_q <= CW'(H_SYNC_E)));
            vs_d      = !((v_q >= CW'(V_SYNC_S)) && (v_q <= CW'(V_SYNC_E)));
            blank_n_d = visible_c;
            {r_d, g_d, b_d} = visible_c ? pixel_c : 24'h0;
            if (h_q == CW'(H_LAST)) begin
                h_d = '0;
                v_d = (v_q == CW'(V_LAST)) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    // PS/2 receiver: synchronise, shift on falling edges, validate complete 11-bit frames
    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[0], PS2_CLK};
        ps2d_sync_d = {ps2d_sync_q[0], PS2_DAT};
        ps2c_prev_d = ps2c_sync_q[1];
        fall_c      = ps2c_prev_q & ~ps2c_sync_q[1];
        frame_c     = {ps2d_sync_q[1], shift_q};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wd_d        = wd_q;
        byte_ok_c   = 1'b0;
        if (fall_c) begin
            wd_d    = '0;
            shift_d = {ps2d_sync_q[1], shift_q[9:1]};
            if (bit_cnt_q == BCW'(10)) begin
                bit_cnt_d = '0;
                byte_ok_c = ~frame_c[0] & (^frame_c[9:1]) & frame_c[10];
            end else begin
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end
        end else if (bit_cnt_q != '0) begin
            if (wd_q == {WDW{1'b1}}) begin
                bit_cnt_d = '0;
                wd_d      = '0;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    // Scancode decoder; a break prefix swallows the following byte
    always_comb begin
        colour_d    = colour_q;
        brk_d       = brk_q;
        suspended_d = suspended_q;
        if (byte_ok_c && !suspended_q) begin
            if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                case (frame_c[8:1])
                    KEY_BRK:   brk_d = 1'b1;
                    KEY_EXT:   brk_d = 1'b0;
                    KEY_R:     colour_d[23:16] = colour_q[23:16] ^ 8'hFF;
                    KEY_G:     colour_d[15:8]  = colour_q[15:8] ^ 8'hFF;
                    KEY_B:     colour_d[7:0]   = colour_q[7:0] ^ 8'hFF;
                    KEY_SPACE: colour_d = COLOUR_RST;
                    KEY_ESC:   suspended_d = 1'b1;
                    default:   brk_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pe_q        <= 1'b0;
            vga_clk_q   <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_n_q   <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            ps2c_sync_q <= 2'b11;
            ps2d_sync_q <= 2'b11;
            ps2c_prev_q <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wd_q        <= '0;
            colour_q    <= COLOUR_RST;
            brk_q       <= 1'b0;
            suspended_q <= 1'b0;
        end else begin
            pe_q        <= pe_d;
            vga_clk_q   <= vga_clk_d;
            h_q         <= h_d;
            v_q         <= v_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            ps2c_prev_q <= ps2c_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wd_q        <= wd_d;
            colour_q    <= colour_d;
            brk_q       <= brk_d;
            suspended_q <= suspended_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign suspended   = suspended_q;

endmodule

// File: tb/tb_lalu_top.sv
// Bench for lalu_top: VGA outputs predicted from the edge count since reset, colour from a key-level model.
module tb_lalu_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2c_drv, ps2d_drv;
    wire         ps2_clk_w, ps2_dat_w;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_clk, vga_sync_n, vga_blank_n, vga_hs, vga_vs, susp;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned k;
    logic [23:0] m_colour;
    logic        m_brk, m_susp;

    assign ps2_clk_w = ps2c_drv;
    assign ps2_dat_w = ps2d_drv;

    lalu_top dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .PS2_CLK     (ps2_clk_w),
        .PS2_DAT     (ps2_dat_w),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_CLK     (vga_clk),
        .VGA_SYNC_N  (vga_sync_n),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .suspended   (susp)
    );

    always #10 clk = ~clk;

    // Rising edges seen since reset was released
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic logic [23:0] pix(input int unsigned h, input logic [23:0] col);
        logic [23:0] p;
        logic [2:0]  i;
        i = 3'(h / 80);
        p = col;
`ifdef LALU_TEST_PATTERN_EN
        p = {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
`endif
        return p;
    endfunction

    // Output word after rising edge kk: pixel n = kk/2-1 is on the outputs once kk >= 2
    function automatic logic [29:0] expect_out(input int unsigned kk, input logic [23:0] col, input logic su);
        int unsigned n, h, v;
        logic        vis, hs_e, vs_e, vck;
        logic [23:0] rgb;
        hs_e = 1'b1; vs_e = 1'b1; vis = 1'b0; rgb = '0; vck = 1'b0;
        if (kk >= 2) begin
            n    = kk / 2 - 1;
            h    = n % 800;
            v    = (n / 800) % 525;
            hs_e = !(h >= 656 && h < 752);
            vs_e = !(v >= 490 && v < 492);
            vis  = (h < 640) && (v < 480);
            rgb  = vis ? pix(h, col) : 24'h0;
            vck  = (kk % 2) == 0;
        end
        return {vck, 1'b0, hs_e, vs_e, vis, rgb, su};
    endfunction

    function automatic logic [29:0] observed();
        return {vga_clk, vga_sync_n, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, susp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_window(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, 32'(observed()), 32'(expect_out(k, m_colour, m_susp)));
        end
    endtask

    // Key-level behaviour of the decoder
    task automatic model_key(input logic [7:0] code);
        if (m_susp) return;
        if (m_brk) begin
            m_brk = 1'b0;
            return;
        end
        case (code)
            8'hF0: m_brk = 1'b1;
            8'h2D: m_colour[23:16] = ~m_colour[23:16];
            8'h34: m_colour[15:8]  = ~m_colour[15:8];
            8'h32: m_colour[7:0]   = ~m_colour[7:0];
            8'h29: m_colour = 24'h000080;
            8'h76: m_susp = 1'b1;
            default: ;
        endcase
    endtask

    // Device-to-host frame; nbits < 11 leaves a partial frame on the wire
    task automatic ps2_send(input logic [7:0] data, input bit bad_par, input int nbits);
        logic [10:0] f;
        int          half;
        f    = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        half = int'($urandom_range(8, 16));
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d_drv = f[i];
            repeat (half / 2) @(negedge clk);
            ps2c_drv = 1'b0;
            repeat (half) @(negedge clk);
            ps2c_drv = 1'b1;
            repeat (half / 2) @(negedge clk);
        end
        ps2d_drv = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] code, input string tag);
        ps2_send(code, 1'b0, 11);
        model_key(code);
        check_window(500, tag);
    endtask

    logic [7:0] pool [8];
    int         hs_low, blank_hi;

    initial begin
        pool = '{8'h2D, 8'h34, 8'h32, 8'h29, 8'hE0, 8'hF0, 8'h11, 8'h1C};
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
        m_colour = 24'h000080;
        m_brk    = 1'b0;
        m_susp   = 1'b0;
        rst_n    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_state", 32'(observed()), 32'(expect_out(0, m_colour, 1'b0)));
        rst_n = 1'b1;

        // First line: explicit sync/blank pixel counts plus full output prediction
        hs_low = 0;
        blank_hi = 0;
        do @(negedge clk); while (k < 2);
        for (int i = 0; i < 1600; i++) begin
            if (i != 0) @(negedge clk);
            check("line0", 32'(observed()), 32'(expect_out(k, m_colour, m_susp)));
            if (!vga_hs) hs_low++;
            if (vga_blank_n) blank_hi++;
        end
        check("hs_low_cycles", 32'(hs_low), 32'd192);
        check("blank_hi_cycles", 32'(blank_hi), 32'd1280);

        key(8'h2D, "key_r");
        key(8'hF0, "brk_prefix");
        key(8'h2D, "brk_swallow");

        ps2_send(8'h34, 1'b1, 11);
        check_window(300, "bad_parity");
        key(8'h34, "key_g");

        ps2_send(8'h32, 1'b0, 5);
        repeat (70000) @(negedge clk);
        key(8'h32, "wd_recover");

        for (int i = 0; i < 6; i++) key(pool[$urandom_range(0, 7)], "random_key");
        key(8'h11, "clear_brk");

        key(8'h76, "esc");
        key(8'h2D, "suspended_ignore");
        key(8'h29, "suspended_ignore2");

        // Reset in the middle of a PS/2 frame and mid-line
        ps2_send(8'h34, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        m_colour = 24'h000080;
        m_brk    = 1'b0;
        m_susp   = 1'b0;
        #1;
        check("reset_mid", 32'(observed()), 32'(expect_out(0, m_colour, 1'b0)));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_window(600, "after_reset");
        key(8'h2D, "post_reset_key");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
